// File: rtl/park_pkg.sv
// rtl/park_pkg.sv - shared types, widths and output saturation for the Park sequencer
package park_pkg;

    localparam int DEF_D_WIDTH = 18;
    localparam int DEF_Q_BITS  = 15;
    localparam int ACC_W       = 2 * DEF_D_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        HOLD = 3'd5
    } park_state_t;

    typedef struct packed {
        logic signed [63:0] value;
        logic               clip;
    } sat_res_t;

    // Floor-shift the accumulator back to output scale, then clamp to d_width bits.
    function automatic sat_res_t sat_trunc(input logic signed [63:0] acc,
                                           input int                 q_bits,
                                           input int                 d_width);
        sat_res_t           r;
        logic signed [63:0] sh;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sh      = acc >>> q_bits;
        hi      = (64'sd1 <<< (d_width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (d_width - 1));
        r.value = sh;
        r.clip  = 1'b0;
        if (sh > hi) begin
            r.value = hi;
            r.clip  = 1'b1;
        end else if (sh < lo) begin
            r.value = lo;
            r.clip  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/park_mac.sv
// rtl/park_mac.sv - one shared signed multiplier stepped over four cycles into two accumulators
module park_mac
    import park_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  park_state_t               state,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin,
    input  logic signed [D_WIDTH-1:0] cos,
    output logic signed [2*D_WIDTH:0] acc_d,
    output logic signed [2*D_WIDTH:0] acc_q,
    output logic signed [2*D_WIDTH:0] acc_d_nxt,
    output logic signed [2*D_WIDTH:0] acc_q_nxt
);

    localparam int PW = 2 * D_WIDTH;

    logic signed [D_WIDTH-1:0] mul_a;
    logic signed [D_WIDTH-1:0] mul_b;
    logic signed [PW-1:0]      prod;
    logic signed [PW:0]        term;
    logic                      en_d;
    logic                      en_q;
    logic                      sub;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        en_d  = 1'b0;
        en_q  = 1'b0;
        sub   = 1'b0;
        case (state)
            MUL0: begin mul_a = alpha; mul_b = cos; en_d = 1'b1; end
            MUL1: begin mul_a = beta;  mul_b = sin; en_d = 1'b1; end
            MUL2: begin mul_a = beta;  mul_b = cos; en_q = 1'b1; end
            MUL3: begin mul_a = alpha; mul_b = sin; en_q = 1'b1; sub = 1'b1; end
            default: ;
        endcase
        prod      = PW'(mul_a) * PW'(mul_b);
        term      = {prod[PW-1], prod};
        acc_d_nxt = acc_d;
        acc_q_nxt = acc_q;
        if (en_d) acc_d_nxt = acc_d + term;
        if (en_q) acc_q_nxt = sub ? (acc_q - term) : (acc_q + term);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_d <= '0;
            acc_q <= '0;
        end else begin
            acc_d <= acc_d_nxt;
            acc_q <= acc_q_nxt;
        end
    end

endmodule

// File: rtl/park_seq.sv
// rtl/park_seq.sv - sequenced Park transform: handshakes, FSM and saturated D/Q output registers
module park_seq
    import park_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int Q_BITS  = DEF_Q_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic signed [D_WIDTH-1:0] sin,
    input  logic signed [D_WIDTH-1:0] cos,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_WIDTH-1:0] D,
    output logic signed [D_WIDTH-1:0] Q,
    output logic                      sat
);

    park_state_t state_q;
    park_state_t state_d;

    logic signed [D_WIDTH-1:0] op_alpha;
    logic signed [D_WIDTH-1:0] op_beta;
    logic signed [D_WIDTH-1:0] op_sin;
    logic signed [D_WIDTH-1:0] op_cos;
    logic signed [2*D_WIDTH:0] acc_d;
    logic signed [2*D_WIDTH:0] acc_q;
    logic signed [2*D_WIDTH:0] acc_d_nxt;
    logic signed [2*D_WIDTH:0] acc_q_nxt;
    logic                      accept;
    sat_res_t                  res_d;
    sat_res_t                  res_q;
    logic                      unused_sat_bits;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    park_mac #(.D_WIDTH(D_WIDTH)) u_mac (
        .clk       (clk),
        .reset     (reset),
        .clear     (accept),
        .state     (state_q),
        .alpha     (op_alpha),
        .beta      (op_beta),
        .sin       (op_sin),
        .cos       (op_cos),
        .acc_d     (acc_d),
        .acc_q     (acc_q),
        .acc_d_nxt (acc_d_nxt),
        .acc_q_nxt (acc_q_nxt)
    );

    // Sample the combinational next values so the MUL3 product lands in this result.
    always_comb begin
        res_d = sat_trunc(64'(acc_d_nxt), Q_BITS, D_WIDTH);
        res_q = sat_trunc(64'(acc_q_nxt), Q_BITS, D_WIDTH);
    end

    assign unused_sat_bits = ^{res_d.value[63:D_WIDTH], res_q.value[63:D_WIDTH], acc_d, acc_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MUL0;
            MUL0:    state_d = MUL1;
            MUL1:    state_d = MUL2;
            MUL2:    state_d = MUL3;
            MUL3:    state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_alpha  <= '0;
            op_beta   <= '0;
            op_sin    <= '0;
            op_cos    <= '0;
            D         <= '0;
            Q         <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                op_alpha <= alpha;
                op_beta  <= beta;
                op_sin   <= sin;
                op_cos   <= cos;
            end
            if (state_q == MUL3) begin
                D         <= res_d.value[D_WIDTH-1:0];
                Q         <= res_q.value[D_WIDTH-1:0];
                sat       <= res_d.clip | res_q.clip;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
